// File: rtl/typing_session_ctrl.sv
// typing_session_ctrl: one TypeRacer round (idle -> countdown -> run -> done) with the typed
// buffer, per-character correct mask, seconds timer and keystroke/error counters.
// Optional macro TYPING_STRICT_EN: mismatching keys are counted but never written.
module typing_session_ctrl #(
    parameter int N_CHARS      = 25,
    parameter int CLK_HZ       = 100000000,
    parameter int COUNTDOWN_S  = 3,
    parameter int TIME_LIMIT_S = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 key_valid,
    input  logic [4:0]           key_code,
    input  logic [5*N_CHARS-1:0] target,
    output logic [5*N_CHARS-1:0] typed,
    output logic [N_CHARS-1:0]   correct,
    output logic [4:0]           cursor,
    output logic [1:0]           state,
    output logic [3:0]           countdown,
    output logic [6:0]           elapsed_sec,
    output logic [7:0]           keystrokes,
    output logic [7:0]           errors,
    output logic                 done
);
    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BUF_W   = 5 * N_CHARS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [BUF_W-1:0]   r_tgt;
    logic [BUF_W-1:0]   r_typed;
    logic [N_CHARS-1:0] r_correct;
    logic [4:0]         r_cursor;
    logic [3:0]         r_countdown;
    logic [6:0]         r_elapsed;
    logic [7:0]         r_keys;
    logic [7:0]         r_errs;
    logic               r_done;

    logic [7:0] w_wr_base;
    logic [7:0] w_bs_base;
    logic [4:0] w_tgt_char;
    logic       w_tick;
    logic       w_printable;
    logic       w_backspace;
    logic       w_match;
    logic       w_write;
    logic       w_line_full;
    logic       w_time_up;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        w_tick      = (r_presc == PRESC_W'(CLK_HZ - 1));
        w_wr_base   = 8'(r_cursor) * 8'd5;
        w_bs_base   = w_wr_base - 8'd5;
        w_tgt_char  = r_tgt[w_wr_base +: 5];
        w_printable = key_valid && (key_code >= 5'd1) && (key_code <= 5'd27);
        w_backspace = key_valid && (key_code == 5'd31);
        w_match     = (key_code == w_tgt_char);
`ifdef TYPING_STRICT_EN
        w_write     = w_printable && w_match;
`else
        w_write     = w_printable;
`endif
        w_line_full = w_write && (r_cursor == 5'(N_CHARS - 1));
        w_time_up   = w_tick && (r_elapsed == 7'(TIME_LIMIT_S - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_typed     <= '0;
            r_correct   <= '0;
            r_cursor    <= '0;
            r_countdown <= '0;
            r_elapsed   <= '0;
            r_keys      <= '0;
            r_errs      <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_COUNTDOWN;
                        r_tgt       <= target;
                        r_presc     <= '0;
                        r_typed     <= '0;
                        r_correct   <= '0;
                        r_cursor    <= '0;
                        r_countdown <= 4'(COUNTDOWN_S);
                        r_elapsed   <= '0;
                        r_keys      <= '0;
                        r_errs      <= '0;
                        r_done      <= 1'b0;
                    end
                end
                S_COUNTDOWN: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        r_countdown <= r_countdown - 4'd1;
                        if (r_countdown == 4'd1) begin
                            r_state   <= S_RUN;
                            r_presc   <= '0;
                            r_elapsed <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) r_elapsed <= r_elapsed + 7'd1;
                    if (w_printable) begin
                        r_keys <= sat_inc(r_keys);
                        if (!w_match) r_errs <= sat_inc(r_errs);
                    end
                    if (w_write) begin
                        r_typed[w_wr_base +: 5] <= key_code;
                        r_correct[r_cursor]     <= w_match;
                        r_cursor                <= r_cursor + 5'd1;
                    end else if (w_backspace && (r_cursor != 5'd0)) begin
                        r_typed[w_bs_base +: 5]      <= 5'd0;
                        r_correct[r_cursor - 5'd1]   <= 1'b0;
                        r_cursor                     <= r_cursor - 5'd1;
                    end
                    // A key landing on the final tick is applied before the round closes.
                    if (w_line_full || w_time_up) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign typed       = r_typed;
    assign correct     = r_correct;
    assign cursor      = r_cursor;
    assign state       = r_state;
    assign countdown   = r_countdown;
    assign elapsed_sec = r_elapsed;
    assign keystrokes  = r_keys;
    assign errors      = r_errs;
    assign done        = r_done;
endmodule

// File: tb/tb_typing_session_ctrl.sv
// Bench for typing_session_ctrl: directed scenarios plus random key traffic checked against
// a cycle-count based model of a round (phase, time since entry, slot array, counters).
module tb_typing_session_ctrl;
    localparam int N  = 25;
    localparam int HZ = 10;
    localparam int CD = 3;
    localparam int TL = 60;
    localparam int SW = 5*N + N + 5 + 2 + 4 + 7 + 8 + 8 + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           key_valid = 1'b0;
    logic [4:0]     key_code = 5'd0;
    logic [5*N-1:0] target = '0;
    logic [5*N-1:0] typed;
    logic [N-1:0]   correct;
    logic [4:0]     cursor;
    logic [1:0]     state;
    logic [3:0]     countdown;
    logic [6:0]     elapsed_sec;
    logic [7:0]     keystrokes;
    logic [7:0]     errors;
    logic           done;

    int total = 0;
    int bad   = 0;

    // Model: phase 0..3, cycles since entering COUNTDOWN/RUN, slot contents, counters.
    int m_phase = 0, m_t = 0, m_cur = 0, m_ks = 0, m_err = 0, m_el = 0;
    int m_tgt[N];
    int m_typ[N];

    typing_session_ctrl #(.N_CHARS(N), .CLK_HZ(HZ), .COUNTDOWN_S(CD), .TIME_LIMIT_S(TL)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
        .target(target), .typed(typed), .correct(correct), .cursor(cursor), .state(state),
        .countdown(countdown), .elapsed_sec(elapsed_sec), .keystrokes(keystrokes),
        .errors(errors), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_typ[i] = 0;
        m_cur = 0; m_ks = 0; m_err = 0; m_el = 0; m_t = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit kv, input logic [4:0] kc,
                              input logic [5*N-1:0] tg);
        int code;
        code = int'(kc);
        if (r) begin
            m_phase = 0;
            model_clear();
        end else if (m_phase == 0 || m_phase == 3) begin
            if (s) begin
                m_phase = 1;
                model_clear();
                for (int i = 0; i < N; i++) m_tgt[i] = int'(tg[5*i +: 5]);
            end
        end else if (m_phase == 1) begin
            m_t++;
            if (m_t == CD * HZ) begin
                m_phase = 2; m_t = 0; m_el = 0;
            end
        end else begin
            if (kv && code >= 1 && code <= 27) begin
                m_ks = (m_ks < 255) ? m_ks + 1 : 255;
                if (code != m_tgt[m_cur]) m_err = (m_err < 255) ? m_err + 1 : 255;
`ifdef TYPING_STRICT_EN
                if (code == m_tgt[m_cur]) begin m_typ[m_cur] = code; m_cur++; end
`else
                m_typ[m_cur] = code; m_cur++;
`endif
            end else if (kv && code == 31 && m_cur > 0) begin
                m_cur--; m_typ[m_cur] = 0;
            end
            m_t++;
            m_el = m_t / HZ;
            if (m_cur == N || m_el == TL) m_phase = 3;
        end
    endtask

    function automatic logic [SW-1:0] exp_snap();
        logic [5*N-1:0] ty;
        logic [N-1:0]   co;
        int             cdv;
        for (int i = 0; i < N; i++) begin
            ty[5*i +: 5] = 5'(m_typ[i]);
            co[i] = (m_typ[i] != 0) && (m_typ[i] == m_tgt[i]);
        end
        cdv = (m_phase == 1) ? CD - m_t / HZ : 0;
        return {ty, co, 5'(m_cur), 2'(m_phase), 4'(cdv), 7'(m_el), 8'(m_ks), 8'(m_err),
                (m_phase == 3)};
    endfunction

    function automatic logic [SW-1:0] dut_snap();
        return {typed, correct, cursor, state, countdown, elapsed_sec, keystrokes, errors, done};
    endfunction

    function automatic logic [5*N-1:0] rand_target();
        logic [5*N-1:0] v;
        for (int i = 0; i < N; i++) v[5*i +: 5] = 5'($urandom_range(1, 27));
        return v;
    endfunction

    task automatic step(input bit s, input bit kv, input logic [4:0] kc);
        start = s; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_edge(rst, s, kv, kc, target);
        #1;
        start = 1'b0; key_valid = 1'b0; key_code = 5'd0;
    endtask

    task automatic enter_run();
        rst = 1'b1; step(0, 0, 5'd0); rst = 1'b0;
        target = rand_target();
        step(1, 0, 5'd0);
        for (int n = 0; n < CD * HZ; n++) step(0, 0, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 5'd0);
        step(1, 1, 5'd3);
        rst = 1'b0;
        total++; if (dut_snap() !== '0) begin bad++;
            $display("FAIL reset_zero got=%h want=0", dut_snap()); end
        total++; if (state !== 2'd0) begin bad++;
            $display("FAIL reset_state got=%0d want=0", state); end
    endtask

    task automatic test_countdown();
        target = rand_target();
        target[4:0] = 5'd1;
        target[9:5] = 5'd3;
        step(1, 0, 5'd0);
        total++; if (state !== 2'd1 || countdown !== 4'd3) begin bad++;
            $display("FAIL cd_entry got state=%0d cd=%0d want 1/3", state, countdown); end
        target = rand_target();
        for (int n = 1; n <= CD * HZ; n++) begin
            step(0, n == 15, 5'd5);
            total++; if (dut_snap() !== exp_snap()) begin bad++;
                $display("FAIL cd_cycle%0d got=%h want=%h", n, dut_snap(), exp_snap()); end
            if (n == 10) begin total++; if (countdown !== 4'd2) begin bad++;
                $display("FAIL cd_at10 got=%0d want=2", countdown); end end
            if (n == 20) begin total++; if (countdown !== 4'd1) begin bad++;
                $display("FAIL cd_at20 got=%0d want=1", countdown); end end
            if (n == 15) begin total++; if (typed !== '0) begin bad++;
                $display("FAIL cd_key_ignored got=%h want=0", typed); end end
        end
        total++; if (state !== 2'd2 || countdown !== 4'd0) begin bad++;
            $display("FAIL cd_to_run got state=%0d cd=%0d want 2/0", state, countdown); end
    endtask

    task automatic test_keys_backspace();
        step(0, 1, 5'd1);
        step(0, 1, 5'd2);
        total++; if (dut_snap() !== exp_snap()) begin bad++;
            $display("FAIL keys_model got=%h want=%h", dut_snap(), exp_snap()); end
        total++; if (keystrokes !== 8'd2 || errors !== 8'd1 || correct[1:0] !== 2'b01) begin bad++;
            $display("FAIL keys_counts got ks=%0d err=%0d c=%b want 2/1/01",
                     keystrokes, errors, correct[1:0]); end
`ifdef TYPING_STRICT_EN
        total++; if (cursor !== 5'd1 || typed[9:0] !== 10'd1) begin bad++;
            $display("FAIL strict_hold got cur=%0d typed=%h want 1/001", cursor, typed[9:0]); end
`else
        total++; if (cursor !== 5'd2 || typed[4:0] !== 5'd1 || typed[9:5] !== 5'd2) begin bad++;
            $display("FAIL keys_written got cur=%0d t0=%0d t1=%0d want 2/1/2",
                     cursor, typed[4:0], typed[9:5]); end
        step(0, 1, 5'd31);
        total++; if (cursor !== 5'd1 || typed[9:5] !== 5'd0 || correct[1] !== 1'b0
                     || errors !== 8'd1) begin bad++;
            $display("FAIL bs_first got cur=%0d t1=%0d c1=%b err=%0d want 1/0/0/1",
                     cursor, typed[9:5], correct[1], errors); end
`endif
        step(0, 1, 5'd31);
        total++; if (cursor !== 5'd0) begin bad++;
            $display("FAIL bs_second got=%0d want=0", cursor); end
        step(0, 1, 5'd31);
        total++; if (cursor !== 5'd0 || dut_snap() !== exp_snap()) begin bad++;
            $display("FAIL bs_at_zero got=%h want=%h", dut_snap(), exp_snap()); end
    endtask

    task automatic test_random();
        int sel;
        logic [4:0] kc;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 11);
            if (sel == 11) target = rand_target();
            if (sel <= 3) begin
                kc = (m_cur < N) ? 5'(m_tgt[m_cur]) : 5'd1;
                step(0, 1, kc);
            end else if (sel <= 5) step(0, 1, 5'($urandom_range(1, 27)));
            else if (sel == 6) step(0, 1, 5'd31);
            else if (sel == 7) step(0, 1, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(28, 30)));
            else if (sel == 8) step(1, 0, 5'd0);
            else step(0, 0, 5'd0);
            total++; if (dut_snap() !== exp_snap()) begin bad++;
                $display("FAIL random_cyc%0d got=%h want=%h", n, dut_snap(), exp_snap()); end
        end
    endtask

    task automatic test_full_line();
        logic [SW-1:0] held;
        enter_run();
        for (int i = 0; i < N; i++) begin
            step(0, 1, 5'(m_tgt[i]));
            total++; if (dut_snap() !== exp_snap()) begin bad++;
                $display("FAIL full_key%0d got=%h want=%h", i, dut_snap(), exp_snap()); end
        end
        total++; if (state !== 2'd3 || done !== 1'b1 || correct !== {N{1'b1}}) begin bad++;
            $display("FAIL full_done got state=%0d done=%b c=%h want 3/1/all", state, done, correct); end
        held = dut_snap();
        for (int i = 0; i < 3; i++) step(0, 1, 5'($urandom_range(1, 31)));
        total++; if (dut_snap() !== held) begin bad++;
            $display("FAIL done_hold got=%h want=%h", dut_snap(), held); end
        step(1, 0, 5'd0);
        total++; if (state !== 2'd1 || typed !== '0 || cursor !== 5'd0 || done !== 1'b0) begin bad++;
            $display("FAIL restart got state=%0d typed=%h cur=%0d want 1/0/0", state, typed, cursor); end
    endtask

    task automatic test_timeout();
        enter_run();
        for (int n = 1; n < TL * HZ; n++) step(0, 0, 5'd0);
        total++; if (state !== 2'd2 || elapsed_sec !== 7'd59) begin bad++;
            $display("FAIL pre_timeout got state=%0d el=%0d want 2/59", state, elapsed_sec); end
        step(0, 1, 5'(m_tgt[0]));
        total++; if (state !== 2'd3 || elapsed_sec !== 7'd60 || done !== 1'b1) begin bad++;
            $display("FAIL timeout got state=%0d el=%0d want 3/60", state, elapsed_sec); end
        total++; if (cursor !== 5'd1 || typed[4:0] !== 5'(m_tgt[0])) begin bad++;
            $display("FAIL timeout_key got cur=%0d t0=%0d want 1/%0d", cursor, typed[4:0], m_tgt[0]); end
    endtask

    task automatic test_mid_reset();
        enter_run();
        for (int i = 0; i < 7; i++) step(0, 1, 5'(m_tgt[i]));
        total++; if (cursor !== 5'd7) begin bad++;
            $display("FAIL pre_reset_cursor got=%0d want=7", cursor); end
        rst = 1'b1;
        step(0, 1, 5'd4);
        rst = 1'b0;
        total++; if (dut_snap() !== '0) begin bad++;
            $display("FAIL mid_reset got=%h want=0", dut_snap()); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_tgt[i] = 0; m_typ[i] = 0; end
        test_reset();
        test_countdown();
        test_keys_backspace();
        test_random();
        test_full_line();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
